fetch_buffer: RTL

Instruction fetch front end sitting directly upstream of the ID-stage instruction decoder. Issues sequential word fetches to instruction memory over a valid/ready request channel, accepts in-order responses, and queues fetched instructions with their PCs in a small FIFO. Presents the head entry, pre-split into Op/Fn3/Fn7 fields, to the decoder under a valid/ready handshake. Supports a redirect (branch/jump) that flushes queued entries and squashes in-flight responses.

---
 rtl/fetch_buffer_pkg.sv | 39 +++
 rtl/fetch_buffer_fifo.sv | 95 +++++++++
 rtl/fetch_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_buffer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_buffer_pkg
//   Shared definitions for the instruction fetch front end:
//   - instruction field bit positions (op / fn3 / fn7)
//   - default reset fetch address
//   - NOP encoding (used by downstream flush insertion)
//   - fetch FSM state type and FIFO entry layout
//   - word-alignment helper for redirect targets
// -----------------------------------------------------------------------------
package fetch_buffer_pkg;

  // Instruction field positions
  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned OP_MSB  = 6;
  localparam int unsigned FN3_LSB = 12;
  localparam int unsigned FN3_MSB = 14;
  localparam int unsigned FN7_LSB = 25;
  localparam int unsigned FN7_MSB = 31;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef enum logic [1:0] {
    FB_BOOT  = 2'd0,
    FB_FETCH = 2'd1,
    FB_DRAIN = 2'd2
  } fb_state_e;

  // FIFO entry: PC in the upper word, instruction in the lower word
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fb_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
//   Small synchronous FIFO with push / pop / flush and an occupancy count.
//   Used both as the fetched-instruction queue ({pc, instr}) and as the
//   in-flight request PC queue.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     push         write push_data at the tail (ignored when full unless
//                  a pop happens in the same cycle)
//     push_data    entry to write
//     pop          drop the head entry (ignored when empty)
//     flush        empty the FIFO; takes priority over push and pop
//     head_data    current head entry (registered storage, no bypass)
//     count        number of valid entries (0..DEPTH)
//     empty, full  occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !flush));

endmodule

// File: rtl/fetch_buffer.sv
// -----------------------------------------------------------------------------
// fetch_buffer
//   Instruction fetch front end feeding the ID-stage decoder. Issues
//   sequential word fetches, queues in-order responses with their PCs and
//   presents the head entry (pre-split into op/fn3/fn7) to the decoder.
//   A redirect flushes the queue and squashes responses still in flight.
//
//   Parameters:
//     DEPTH     queue entries (power of two, >= 2); also caps outstanding
//               fetches (outstanding + queued < DEPTH to issue)
//     RESET_PC  first fetch address after reset
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     imem_req_valid/addr/ready   fetch request channel
//     imem_rsp_valid/data         in-order fetch responses
//     redirect_valid/pc           single-cycle redirect, pc[1:0] ignored
//     id_valid/ready              decoder handshake
//     id_instr/pc/op/fn3/fn7      head entry and its decoded fields
// -----------------------------------------------------------------------------
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [6:0]  id_op,
  output logic [2:0]  id_fn3,
  output logic [6:0]  id_fn7
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fb_state_e     state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [CW-1:0] fifo_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_after;
  logic [CW:0]   credit_used;
  logic          fifo_empty, fifo_full;
  logic          pcq_empty, pcq_full;
  logic [31:0]   rsp_pc;
  fb_entry_t     head;
  fb_entry_t     push_entry;

  logic          fire;
  logic          push;
  logic          pop;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  assign credit_used    = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = (state_q == FB_FETCH) && !redirect_valid &&
                          (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign fire           = imem_req_valid && imem_req_ready;

  assign id_valid = !fifo_empty;
  assign pop      = id_valid && id_ready && !redirect_valid;
  // Responses are kept only in FETCH and only when no redirect squashes them.
  assign push     = imem_rsp_valid && (state_q == FB_FETCH) && !redirect_valid;

  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  // ---------------------------------------------------------------------------
  // Instruction queue and in-flight PC queue.
  // The PC queue pops on every response, stale or not, so it is never
  // flushed: stale PCs drain out in step with the stale responses.
  // ---------------------------------------------------------------------------
  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_instr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_pc_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fire),
    .push_data (pc_q),
    .pop       (imem_rsp_valid),
    .flush     (1'b0),
    .head_data (rsp_pc),
    .count     (outstanding),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  assign id_instr = head.instr;
  assign id_pc    = head.pc;
  assign id_op    = head.instr[OP_MSB:OP_LSB];
  assign id_fn3   = head.instr[FN3_MSB:FN3_LSB];
  assign id_fn7   = head.instr[FN7_MSB:FN7_LSB];

  // ---------------------------------------------------------------------------
  // Fetch control
  // ---------------------------------------------------------------------------
  assign outstanding_after = outstanding - CW'(imem_rsp_valid);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;

    if (redirect_valid) begin
      pc_d = align_word(redirect_pc);
    end else if (fire) begin
      pc_d = pc_q + 32'd4;
    end

    unique case (state_q)
      FB_BOOT: begin
        state_d = FB_FETCH;
      end
      FB_FETCH: begin
        // Redirect never coincides with a fire, so every request still
        // outstanding after this cycle's response is stale.
        if (redirect_valid && (outstanding_after != '0)) begin
          state_d   = FB_DRAIN;
          discard_d = outstanding_after;
        end
      end
      FB_DRAIN: begin
        if (imem_rsp_valid) begin
          discard_d = discard_q - CW'(1);
          if (discard_q == CW'(1)) begin
            state_d = FB_FETCH;
          end
        end
      end
      default: begin
        state_d = FB_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FB_BOOT;
      pc_q      <= RESET_PC;
      discard_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_rsp_fifo_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_full && !pop));

  a_rsp_orphan: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && pcq_empty));

  a_fire_credit: assert property (@(posedge clk) disable iff (!rst_n)
    !(fire && pcq_full));

endmodule
